// File: rtl/gfx_write_buffer.sv
// rtl/gfx_write_buffer.sv - pixel write coalescer feeding a MIG user write port
//
// Collects single-pixel writes (x, y, 8-bit colour) into one 32-bit memory word
// and writes that word to the graphics region as a single masked MIG transaction.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   calib_done          MIG calibration complete; gates new words and MIG strobes
//   px_valid/px_ready   pixel handshake; px_x, px_y, px_color carry the pixel
//   flush               force write-out of the pending word
//   busy                a word is pending or being written
//   error               sticky MIG write underrun / error flag
//   mem_cmd_*           MIG command port (single-word write)
//   mem_wr_*            MIG write-data port (data, byte mask, full/underrun/error)

`ifndef GRAPHICS_MEM_PREFIX
`define GRAPHICS_MEM_PREFIX 14'h0000
`endif

module gfx_write_buffer #(
   parameter logic [13:0] ADDR_PREFIX       = `GRAPHICS_MEM_PREFIX,
   parameter int          IDLE_FLUSH_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        calib_done,
   input  logic        px_valid,
   output logic        px_ready,
   input  logic [7:0]  px_x,
   input  logic [7:0]  px_y,
   input  logic [7:0]  px_color,
   input  logic        flush,
   output logic        busy,
   output logic        error,
   output logic        mem_cmd_en,
   output logic [2:0]  mem_cmd_instr,
   output logic [5:0]  mem_cmd_bl,
   output logic [29:0] mem_cmd_byte_addr,
   input  logic        mem_cmd_full,
   output logic        mem_wr_en,
   output logic [31:0] mem_wr_data,
   output logic [3:0]  mem_wr_mask,
   input  logic        mem_wr_full,
   input  logic        mem_wr_underrun,
   input  logic        mem_wr_error
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DATA    = 2'd2,
      S_CMD     = 2'd3
   } state_t;

   localparam logic [7:0] FLUSH_LAST = 8'(IDLE_FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  y_q, y_d;
   logic [5:0]  xw_q, xw_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  mask_q, mask_d;
   logic [7:0]  timer_q, timer_d;
   logic        error_q, error_d;

   logic        word_match;
   logic        accept;
   logic [3:0]  lane_onehot;
   logic [31:0] lane_data;
   logic [31:0] byte_en;

   assign word_match  = (px_y == y_q) && (px_x[7:2] == xw_q);
   assign lane_onehot = 4'b0001 << px_x[1:0];
   assign lane_data   = {24'h0, px_color} << {px_x[1:0], 3'b000};

   always_comb begin
      byte_en = '0;
      for (int i = 0; i < 4; i++) begin
         byte_en[8*i +: 8] = {8{lane_onehot[i]}};
      end
   end

   // A non-matching pixel is refused in COLLECT; it is taken once the
   // current word has been written and the buffer is back in IDLE.
   always_comb begin
      case (state_q)
         S_IDLE:    px_ready = calib_done;
         S_COLLECT: px_ready = word_match;
         default:   px_ready = 1'b0;
      endcase
   end

   assign accept = px_valid && px_ready;

   // Strobes only fire in a cycle the MIG FIFO can take them, so each one is
   // high for exactly one accepted cycle.
   assign mem_wr_en  = (state_q == S_DATA) && calib_done && !mem_wr_full;
   assign mem_cmd_en = (state_q == S_CMD)  && calib_done && !mem_cmd_full;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      xw_d    = xw_q;
      data_d  = data_q;
      mask_d  = mask_q;
      timer_d = timer_q;
      error_d = error_q | mem_wr_underrun | mem_wr_error;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               y_d     = px_y;
               xw_d    = px_x[7:2];
               data_d  = lane_data;
               mask_d  = ~lane_onehot;
               timer_d = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (accept) begin
               data_d  = (data_q & ~byte_en) | lane_data;
               mask_d  = mask_q & ~lane_onehot;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 8'd1;
            end
            // mask_d already includes this cycle's merge, so a fill and its
            // write-out happen on the same edge.
            if ((mask_d == 4'h0) || flush ||
                (!accept && (timer_q == FLUSH_LAST)) ||
                (px_valid && !word_match)) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (mem_wr_en) state_d = S_CMD;
         end
         S_CMD: begin
            if (mem_cmd_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         y_q     <= '0;
         xw_q    <= '0;
         data_q  <= '0;
         mask_q  <= 4'hF;
         timer_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         xw_q    <= xw_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         timer_q <= timer_d;
         error_q <= error_d;
      end
   end

   assign busy              = (state_q != S_IDLE);
   assign error             = error_q;
   assign mem_cmd_instr     = 3'b000;
   assign mem_cmd_bl        = 6'd0;
   assign mem_cmd_byte_addr = {ADDR_PREFIX, y_q, xw_q, 2'b00};
   assign mem_wr_data       = data_q;
   assign mem_wr_mask       = mask_q;

endmodule

// File: tb/tb_gfx_write_buffer.sv
// tb/tb_gfx_write_buffer.sv - scoreboard bench for gfx_write_buffer

module tb_gfx_write_buffer;

   localparam logic [13:0] PREFIX = 14'h0A5A;
   localparam int          FLUSH_N = 16;

   logic        clk;
   logic        rst;
   logic        calib_done;
   logic        px_valid;
   logic        px_ready;
   logic [7:0]  px_x, px_y, px_color;
   logic        flush;
   logic        busy, error;
   logic        mem_cmd_en;
   logic [2:0]  mem_cmd_instr;
   logic [5:0]  mem_cmd_bl;
   logic [29:0] mem_cmd_byte_addr;
   logic        mem_cmd_full;
   logic        mem_wr_en;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_mask;
   logic        mem_wr_full;
   logic        mem_wr_underrun;
   logic        mem_wr_error;

   gfx_write_buffer #(
      .ADDR_PREFIX      (PREFIX),
      .IDLE_FLUSH_CYCLES(FLUSH_N)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .calib_done       (calib_done),
      .px_valid         (px_valid),
      .px_ready         (px_ready),
      .px_x             (px_x),
      .px_y             (px_y),
      .px_color         (px_color),
      .flush            (flush),
      .busy             (busy),
      .error            (error),
      .mem_cmd_en       (mem_cmd_en),
      .mem_cmd_instr    (mem_cmd_instr),
      .mem_cmd_bl       (mem_cmd_bl),
      .mem_cmd_byte_addr(mem_cmd_byte_addr),
      .mem_cmd_full     (mem_cmd_full),
      .mem_wr_en        (mem_wr_en),
      .mem_wr_data      (mem_wr_data),
      .mem_wr_mask      (mem_wr_mask),
      .mem_wr_full      (mem_wr_full),
      .mem_wr_underrun  (mem_wr_underrun),
      .mem_wr_error     (mem_wr_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   int total = 0;
   int bad   = 0;

   // reference model: the word currently being gathered, as a set of bytes
   bit         pend_valid = 0;
   logic [7:0] pend_y;
   logic [5:0] pend_xw;
   logic [7:0] pend_bytes [4];
   bit         pend_have  [4];

   bit          rnd_stall = 0;
   int          acc_cyc = 0;
   int          last_wr_cyc = 0;
   int          last_cmd_cyc = 0;
   int          wr_count = 0;
   int          cmd_count = 0;
   bit          cmd_pend = 0;
   logic [29:0] pend_cmd_addr;
   logic [31:0] hold_data;
   logic [3:0]  hold_mask;
   logic [3:0]  last_wr_mask;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic push_pending();
      wr_t e;
      e.addr = {PREFIX, pend_y, pend_xw, 2'b00};
      e.data = '0;
      e.mask = 4'hF;
      for (int k = 0; k < 4; k++) begin
         if (pend_have[k]) begin
            e.data[8*k +: 8] = pend_bytes[k];
            e.mask[k] = 1'b0;
         end
      end
      exp_q.push_back(e);
      pend_valid = 0;
   endtask

   task automatic model_accept(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
      int lane;
      int filled;
      if (!pend_valid) begin
         pend_valid = 1;
         pend_y = y;
         pend_xw = x[7:2];
         for (int k = 0; k < 4; k++) pend_have[k] = 0;
      end
      lane = int'(x[1:0]);
      pend_bytes[lane] = c;
      pend_have[lane] = 1;
      filled = 0;
      for (int k = 0; k < 4; k++) if (pend_have[k]) filled++;
      if (filled == 4) push_pending();
   endtask

   task automatic stall_rand();
      if (rnd_stall) begin
         mem_wr_full  = ($urandom_range(0, 3) == 0);
         mem_cmd_full = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      stall_rand();
   endtask

   task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c,
                          output bit first_ready);
      bit got;
      int n;
      if (pend_valid && !((y == pend_y) && (x[7:2] == pend_xw))) push_pending();
      px_x = x;
      px_y = y;
      px_color = c;
      px_valid = 1'b1;
      got = 0;
      n = 0;
      first_ready = 0;
      while (!got && n < 300) begin
         @(negedge clk);
         got = px_ready;
         if (n == 0) first_ready = px_ready;
         tick();
         n++;
      end
      px_valid = 1'b0;
      if (!got) begin
         check("px_accept_timeout", 64'(0), 64'(1));
      end else begin
         acc_cyc = cyc;
         model_accept(x, y, c);
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      if (pend_valid) push_pending();
      tick();
      flush = 1'b0;
   endtask

   task automatic gap(input int n);
      if (n > FLUSH_N && pend_valid) push_pending();
      repeat (n) tick();
   endtask

   task automatic wait_idle();
      int n;
      bit idle;
      n = 0;
      idle = 0;
      while (!idle && n < 500) begin
         @(negedge clk);
         idle = !busy && !cmd_pend;
         tick();
         n++;
      end
      if (!idle) check("idle_timeout", 64'(0), 64'(1));
   endtask

   // monitor: every MIG write is matched against the oldest expected word
   initial begin
      logic [31:0] keep;
      forever begin
         @(negedge clk);
         if (rst) begin
            cmd_pend = 0;
         end else begin
            if (mem_wr_en) begin
               check("wr_while_full", 64'(mem_wr_full), 64'(0));
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 64'(1), 64'(0));
               end else begin
                  mon_e = exp_q.pop_front();
                  for (int k = 0; k < 4; k++) keep[8*k +: 8] = {8{~mon_e.mask[k]}};
                  check("wr_mask", 64'(mem_wr_mask), 64'(mon_e.mask));
                  check("wr_data", 64'(mem_wr_data & keep), 64'(mon_e.data & keep));
                  pend_cmd_addr = mon_e.addr;
               end
               cmd_pend = 1;
               hold_data = mem_wr_data;
               hold_mask = mem_wr_mask;
               last_wr_mask = mem_wr_mask;
               last_wr_cyc = cyc;
               wr_count++;
            end
            if (mem_cmd_en) begin
               check("cmd_while_full", 64'(mem_cmd_full), 64'(0));
               if (!cmd_pend) begin
                  check("cmd_without_write", 64'(1), 64'(0));
               end else begin
                  check("cmd_addr", 64'(mem_cmd_byte_addr), 64'(pend_cmd_addr));
                  check("cmd_instr_bl", 64'({mem_cmd_instr, mem_cmd_bl}), 64'(0));
                  check("cmd_data_stable", 64'({mem_wr_data, mem_wr_mask}), 64'({hold_data, hold_mask}));
               end
               cmd_pend = 0;
               last_cmd_cyc = cyc;
               cmd_count++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit fr;
      bit ok;
      int a, wc, cc;
      logic [7:0] rx, ry;
      int r;

      rst = 1'b1;
      calib_done = 1'b0;
      px_valid = 1'b0;
      px_x = '0;
      px_y = '0;
      px_color = '0;
      flush = 1'b0;
      mem_cmd_full = 1'b0;
      mem_wr_full = 1'b0;
      mem_wr_underrun = 1'b0;
      mem_wr_error = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", 64'({px_ready, busy, error, mem_cmd_en, mem_wr_en}), 64'(0));
      check("rst_mask", 64'(mem_wr_mask), 64'(4'hF));
      check("rst_data", 64'(mem_wr_data), 64'(0));
      check("rst_addr", 64'(mem_cmd_byte_addr), 64'({PREFIX, 16'h0}));
      rst = 1'b0;
      calib_done = 1'b1;
      tick();

      // full word on consecutive cycles, with strobe latency
      send_px(8'd8,  8'd5, 8'h11, fr);
      send_px(8'd9,  8'd5, 8'h22, fr);
      send_px(8'd10, 8'd5, 8'h33, fr);
      send_px(8'd11, 8'd5, 8'h44, fr);
      @(negedge clk);
      check("fill_wr_en", 64'(mem_wr_en), 64'(1));
      check("fill_data", 64'(mem_wr_data), 64'(32'h44332211));
      check("fill_mask", 64'(mem_wr_mask), 64'(4'h0));
      tick();
      @(negedge clk);
      check("fill_cmd_en", 64'(mem_cmd_en), 64'(1));
      check("fill_addr", 64'(mem_cmd_byte_addr), 64'({PREFIX, 8'd5, 8'd8}));
      tick();
      @(negedge clk);
      check("fill_ready_back", 64'({px_ready, busy}), 64'(2'b10));
      tick();

      // single pixel flushed by the idle timer
      send_px(8'd2, 8'd0, 8'hAB, fr);
      a = acc_cyc;
      gap(FLUSH_N + 6);
      check("idle_flush_delay", 64'(last_wr_cyc - a), 64'(FLUSH_N));
      check("idle_flush_mask", 64'(last_wr_mask), 64'(4'b1011));
      wait_idle();

      // non-matching pixel waits for the previous word
      send_px(8'd4, 8'd1, 8'h77, fr);
      send_px(8'd200, 8'd1, 8'h99, fr);
      check("mismatch_not_ready", 64'(fr), 64'(0));
      check("mismatch_accept_cyc", 64'(acc_cyc), 64'(last_cmd_cyc + 2));
      do_flush();
      wait_idle();
      check("second_word_mask", 64'(last_wr_mask), 64'(4'b1110));

      // FIFO-full stalls in DATA and CMD
      mem_wr_full = 1'b1;
      mem_cmd_full = 1'b1;
      send_px(8'h10, 8'd3, 8'h5A, fr);
      do_flush();
      ok = 1;
      repeat (10) begin
         @(negedge clk);
         ok = ok && !mem_wr_en && !mem_cmd_en && busy;
         tick();
      end
      check("wr_stall_hold", 64'(ok), 64'(1));
      mem_wr_full = 1'b0;
      @(negedge clk);
      check("wr_after_stall", 64'(mem_wr_en), 64'(1));
      tick();
      ok = 1;
      repeat (10) begin
         @(negedge clk);
         ok = ok && !mem_wr_en && !mem_cmd_en && busy;
         tick();
      end
      check("cmd_stall_hold", 64'(ok), 64'(1));
      mem_cmd_full = 1'b0;
      @(negedge clk);
      check("cmd_after_stall", 64'(mem_cmd_en), 64'(1));
      tick();
      wait_idle();

      // repeated lane: last write wins, one MIG write; flush in IDLE is ignored
      wc = wr_count;
      send_px(8'h20, 8'd7, 8'h01, fr);
      send_px(8'h20, 8'd7, 8'h02, fr);
      do_flush();
      wait_idle();
      check("same_lane_one_write", 64'(wr_count - wc), 64'(1));
      wc = wr_count;
      cc = cmd_count;
      do_flush();
      repeat (20) tick();
      check("idle_flush_ignored", 64'({wr_count - wc, cmd_count - cc}), 64'(0));

      // sticky error, then reset in the middle of CMD
      mem_wr_error = 1'b1;
      tick();
      mem_wr_error = 1'b0;
      @(negedge clk);
      check("error_set", 64'(error), 64'(1));
      tick();
      for (int i = 0; i < 4; i++) send_px(8'(40 + i), 8'd9, 8'(i + 1), fr);
      wait_idle();
      check("error_sticky", 64'(error), 64'(1));
      send_px(8'd60, 8'd9, 8'hC3, fr);
      do_flush();
      @(negedge clk);
      check("pre_rst_wr", 64'(mem_wr_en), 64'(1));
      @(posedge clk);
      #1;
      check("pre_rst_cmd", 64'(mem_cmd_en), 64'(1));
      rst = 1'b1;
      #1;
      check("rst_cmd_drop", 64'({mem_cmd_en, error, busy}), 64'(0));
      check("rst_mid_addr", 64'(mem_cmd_byte_addr), 64'({PREFIX, 16'h0}));
      @(negedge clk);
      tick();
      rst = 1'b0;
      tick();

      // randomized traffic with FIFO back-pressure
      rnd_stall = 1;
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 9);
         if (r < 7) begin
            ry = 8'($urandom_range(0, 1));
            rx = 8'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rx = 8'($urandom_range(0, 255));
            send_px(rx, ry, 8'($urandom_range(0, 255)), fr);
            gap($urandom_range(0, 2));
         end else if (r == 7) begin
            do_flush();
         end else if (r == 8) begin
            gap(FLUSH_N + 6);
         end else begin
            gap($urandom_range(0, 3));
         end
      end
      do_flush();
      rnd_stall = 0;
      mem_wr_full = 1'b0;
      mem_cmd_full = 1'b0;
      wait_idle();
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
